// File: rtl/led_pixel_buffer_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | led_pixel_buffer_if: host byte port, readback and pixel stream      |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
interface led_pixel_buffer_if;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [7:0]  rd_addr;
  logic [7:0]  rd_data;
  logic        frame_sync;
  logic        pix_ready;
  logic        pix_valid;
  logic [23:0] pix_data;
  logic        pix_last;
  logic        commit_pending;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr, frame_sync, pix_ready,
    input  rd_data, pix_valid, pix_data, pix_last, commit_pending
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr, frame_sync, pix_ready,
    output rd_data, pix_valid, pix_data, pix_last, commit_pending
  );
endinterface
`default_nettype wire

// File: rtl/led_pixel_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | led_pixel_buffer: double-buffered RGB store streaming GRB words    |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module led_pixel_buffer #(
  parameter int NUM_PIXELS = 16
) (
  input  logic               clk,
  input  logic               rst,
  led_pixel_buffer_if.slave  bus
);

  localparam int              NUM_BYTES   = 3 * NUM_PIXELS;
  localparam int              AW          = $clog2(NUM_BYTES);
  localparam int              PW          = $clog2(NUM_PIXELS + 1);
  localparam logic [PW-1:0]   PTR_IDLE    = PW'(NUM_PIXELS);
  localparam logic [PW-1:0]   PTR_LAST    = PW'(NUM_PIXELS - 1);
  localparam logic [8:0]      BYTES_END   = 9'(NUM_BYTES);
  localparam logic [7:0]      ADDR_STATUS = 8'hFE;
  localparam logic [7:0]      ADDR_CTRL   = 8'hFF;

  logic [7:0]    r_shadow [NUM_BYTES];
  logic [7:0]    r_active [NUM_BYTES];
  logic [PW-1:0] r_ptr;
  logic          r_commit_pending;
  logic          r_pix_valid;
  logic          r_pix_last;
  logic [23:0]   r_pix_data;
  logic [7:0]    r_rd_data;

  logic          w_commit;
  logic          w_wr_pix;
  logic          w_ctl_set;
  logic [PW-1:0] w_ptr_next;
  logic          w_next_valid;
  logic [AW-1:0] w_base;
  logic [7:0]    w_r, w_g, w_b;
  logic [23:0]   w_pix_word;
  logic [7:0]    w_rd_byte;

  always_comb begin
    w_commit     = bus.frame_sync && r_commit_pending;
    w_wr_pix     = bus.wr_en && ({1'b0, bus.wr_addr} < BYTES_END);
    w_ctl_set    = bus.wr_en && (bus.wr_addr == ADDR_CTRL) && bus.wr_data[0];

    w_ptr_next = r_ptr;
    if (bus.frame_sync)
      w_ptr_next = '0;
    else if (r_pix_valid && bus.pix_ready && (r_ptr < PTR_IDLE))
      w_ptr_next = r_ptr + PW'(1);

    w_next_valid = (w_ptr_next < PTR_IDLE);
    w_base       = AW'(9'(w_ptr_next) * 9'd3);

    // A commit on this edge must already be visible in the first presented pixel.
    if (w_commit) begin
      w_r = r_shadow[w_base];
      w_g = r_shadow[w_base + AW'(1)];
      w_b = r_shadow[w_base + AW'(2)];
    end else begin
      w_r = r_active[w_base];
      w_g = r_active[w_base + AW'(1)];
      w_b = r_active[w_base + AW'(2)];
    end
    w_pix_word = w_next_valid ? {w_g, w_r, w_b} : 24'h000000;

    w_rd_byte = 8'h00;
    if ({1'b0, bus.rd_addr} < BYTES_END)
      w_rd_byte = r_shadow[bus.rd_addr[AW-1:0]];
    else if (bus.rd_addr == ADDR_STATUS)
      w_rd_byte = {6'b0, (r_ptr < PTR_IDLE), r_commit_pending};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        r_shadow[i] <= 8'h00;
        r_active[i] <= 8'h00;
      end
      r_ptr            <= PTR_IDLE;
      r_commit_pending <= 1'b0;
      r_pix_valid      <= 1'b0;
      r_pix_last       <= 1'b0;
      r_pix_data       <= 24'h000000;
      r_rd_data        <= 8'h00;
    end else begin
      if (w_wr_pix)
        r_shadow[bus.wr_addr[AW-1:0]] <= bus.wr_data;
      // Non-blocking copy takes the shadow contents from before any same-edge write.
      if (w_commit)
        r_active <= r_shadow;
      if (w_ctl_set)
        r_commit_pending <= 1'b1;
      else if (w_commit)
        r_commit_pending <= 1'b0;
      r_ptr       <= w_ptr_next;
      r_pix_valid <= w_next_valid;
      r_pix_last  <= (w_ptr_next == PTR_LAST);
      r_pix_data  <= w_pix_word;
      r_rd_data   <= w_rd_byte;
    end
  end

  assign bus.rd_data        = r_rd_data;
  assign bus.pix_valid      = r_pix_valid;
  assign bus.pix_data       = r_pix_data;
  assign bus.pix_last       = r_pix_last;
  assign bus.commit_pending = r_commit_pending;

endmodule
`default_nettype wire

// File: tb/tb_led_pixel_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_led_pixel_buffer: directed scoreboard bench for led_pixel_buffer |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_led_pixel_buffer;

  localparam int NP = 16;
  localparam int NB = 3 * NP;

  logic clk = 1'b0;
  logic rst = 1'b1;
  led_pixel_buffer_if bus ();

  led_pixel_buffer #(.NUM_PIXELS(NP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [7:0]  m_sh [NB];
  logic [7:0]  m_ac [NB];
  bit          m_pend;
  logic [23:0] q [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NB; i++) begin
      m_sh[i] = 8'h00;
      m_ac[i] = 8'h00;
    end
    m_pend = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    if (int'(a) < NB) m_sh[a] = d;
    if (a == 8'hFF && d[0]) m_pend = 1'b1;
    tick();
    bus.wr_en = 1'b0;
  endtask

  // Frame start with the sink ready; optionally a control write in the same cycle.
  task automatic start_frame(input bit ctl);
    if (m_pend) begin
      for (int i = 0; i < NB; i++) m_ac[i] = m_sh[i];
      m_pend = 1'b0;
    end
    if (ctl) m_pend = 1'b1;
    q.delete();
    for (int i = 0; i < NP; i++) q.push_back({m_ac[3*i+1], m_ac[3*i], m_ac[3*i+2]});
    bus.frame_sync = 1'b1;
    bus.pix_ready  = 1'b1;
    if (ctl) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = 8'hFF;
      bus.wr_data = 8'h01;
    end
    tick();
    bus.frame_sync = 1'b0;
    bus.wr_en      = 1'b0;
  endtask

  task automatic stream(input int stop_at, input int stall_at, input int stall_len);
    logic [23:0] exp;
    for (int i = 0; i < NP; i++) begin
      if (i == stop_at) return;
      chk("sb_nonempty", 32'(q.size() != 0), 32'd1);
      exp = (q.size() != 0) ? q[0] : 24'hxxxxxx;
      chk("pix_valid", 32'(bus.pix_valid), 32'd1);
      chk("pix_data", 32'(bus.pix_data), 32'(exp));
      chk("pix_last", 32'(bus.pix_last), 32'(i == NP - 1));
      if (i == stall_at) begin
        bus.pix_ready = 1'b0;
        repeat (stall_len) begin
          tick();
          chk("stall_valid", 32'(bus.pix_valid), 32'd1);
          chk("stall_data", 32'(bus.pix_data), 32'(exp));
        end
        bus.pix_ready = 1'b1;
      end
      tick();
      if (q.size() != 0) void'(q.pop_front());
    end
    chk("valid_after_last", 32'(bus.pix_valid), 32'd0);
    chk("last_after_last", 32'(bus.pix_last), 32'd0);
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.wr_addr = 8'h00; bus.wr_data = 8'h00;
    bus.rd_addr = 8'h00; bus.frame_sync = 1'b0; bus.pix_ready = 1'b0;
    model_clear();

    // Reset
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_valid", 32'(bus.pix_valid), 32'd0);
    chk("rst_last", 32'(bus.pix_last), 32'd0);
    chk("rst_data", 32'(bus.pix_data), 32'd0);
    chk("rst_pending", 32'(bus.commit_pending), 32'd0);
    chk("rst_rd", 32'(bus.rd_data), 32'd0);
    start_frame(1'b0);
    stream(-1, -1, 0);

    // Basic commit
    wr(8'd0, 8'h12); wr(8'd1, 8'h34); wr(8'd2, 8'h56);
    wr(8'hFF, 8'h01);
    chk("pending_set", 32'(bus.commit_pending), 32'd1);
    bus.rd_addr = 8'hFE;
    tick();
    chk("status_pending", 32'(bus.rd_data), 32'h01);
    start_frame(1'b0);
    chk("pixel0_basic", 32'(bus.pix_data), 32'h341256);
    chk("pending_cleared", 32'(bus.commit_pending), 32'd0);
    stream(-1, -1, 0);

    // No tearing
    wr(8'd3, 8'hFF);
    wr(8'hFF, 8'h01);
    start_frame(1'b0);
    stream(-1, -1, 0);
    start_frame(1'b0);
    bus.pix_ready = 1'b0;
    wr(8'd3, 8'h01);
    chk("midframe_hold", 32'(bus.pix_data), 32'(q[0]));
    start_frame(1'b0);
    stream(-1, -1, 0);

    // Distinct pixels and backpressure at pixel 3
    for (int i = 0; i < NB; i++) wr(8'(i), 8'(i * 7 + 3));
    wr(8'hFF, 8'h01);
    start_frame(1'b0);
    stream(-1, 3, 5);

    // Control write coincident with frame_sync, then abort at pixel 7
    wr(8'd0, 8'hAA); wr(8'd1, 8'hBB); wr(8'd2, 8'hCC);
    start_frame(1'b1);
    chk("coincident_pending", 32'(bus.commit_pending), 32'd1);
    stream(-1, -1, 0);
    start_frame(1'b0);
    chk("applied_pixel0", 32'(bus.pix_data), 32'h00BBAACC);
    stream(7, -1, 0);
    start_frame(1'b0);
    stream(-1, -1, 0);

    // Readback, status and unmapped addresses
    wr(8'd2, 8'hAB);
    bus.rd_addr = 8'd2;
    tick();
    chk("rd_byte2", 32'(bus.rd_data), 32'hAB);
    wr(8'hFF, 8'h01);
    bus.rd_addr = 8'hFE;
    tick();
    chk("rd_status_pend", 32'(bus.rd_data), 32'h01);
    wr(8'(NB), 8'h77);
    bus.rd_addr = 8'(NB);
    tick();
    chk("rd_unmapped_wr", 32'(bus.rd_data), 32'h00);
    bus.rd_addr = 8'hFD;
    tick();
    chk("rd_unmapped", 32'(bus.rd_data), 32'h00);
    bus.rd_addr = 8'hFE;
    start_frame(1'b0);
    chk("rd_status_pre", 32'(bus.rd_data), 32'h01);
    bus.pix_ready = 1'b0;
    tick();
    chk("rd_status_stream", 32'(bus.rd_data), 32'h02);
    bus.pix_ready = 1'b1;
    stream(-1, -1, 0);

    // Reset mid-frame
    start_frame(1'b0);
    stream(4, -1, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_clear();
    chk("midrst_valid", 32'(bus.pix_valid), 32'd0);
    chk("midrst_data", 32'(bus.pix_data), 32'd0);
    chk("midrst_pending", 32'(bus.commit_pending), 32'd0);
    bus.rd_addr = 8'd2;
    repeat (3) begin
      tick();
      chk("midrst_idle", 32'(bus.pix_valid), 32'd0);
    end
    chk("midrst_shadow", 32'(bus.rd_data), 32'h00);
    start_frame(1'b0);
    stream(-1, -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
